i2s_ns_feeder: RTL and testbench
================================

Name: i2s_ns_feeder

Overview:
Upstream stage of the fixed-point audio noise suppressor. It oversamples an external I2S bus (BCLK, LRCLK, SDATA) in the system clock domain and deserialises MSB-first slots into FIXWID-bit two's-complement samples. It selects or mixes channels and hands each sample to the suppressor over the toggle req/ack handshake. Overrun and framing faults are flagged as sticky bits.

Parameters:
FIXWID, 16, sample width; must match the suppressor data width
SYNC_STAGES, 2, synchroniser flops on i2s_bclk, i2s_lrclk and i2s_sdata (min 2)
MAX_SLOT_BITS, 32, slot length above which frame_err is set

Ports:
clk  in  1  system clock; must be at least 4x BCLK
rst  in  1  synchronous active-high reset
enable  in  1  clock enable; all state holds while low
i2s_bclk  in  1  asynchronous I2S bit clock
i2s_lrclk  in  1  asynchronous word select; 0 = left, 1 = right
i2s_sdata  in  1  asynchronous serial data, MSB first, standard I2S one-bit delay
chan_sel  in  2  00 = left, 01 = right, 10 = (L+R)>>>1, 11 = mute (no requests)
err_clr  in  1  one-cycle pulse that clears overrun and frame_err
rx_data  out  FIXWID  sample to the suppressor; stable from the req toggle until ack
req  out  1  toggles once per issued sample
ack  in  1  toggle from the suppressor; one toggle completes one request
overrun  out  1  sticky: a sample was dropped because the previous request was unacked
frame_err  out  1  sticky: a slot exceeded MAX_SLOT_BITS bits
busy  out  1  high while a request is outstanding

Behaviour:
- Interface rule: one clock, clk. Reset rst is synchronous and active-high. All flops update only on the rising edge of clk and only when enable=1, except rst, which acts regardless of enable.
- Reset values: rx_data=0, req=0, overrun=0, frame_err=0, busy=0. Internal state after reset: bit counter 0, shift word 0, held left sample 0, ack_d=0, previous sampled lrclk=0, previous bclk=0.
- Synchronisation: each I2S input passes through SYNC_STAGES flops.
- Edge detection: a bclk rising edge is sync_bclk=1 and prev_bclk=0. On that cycle the block samples sync_sdata and sync_lrclk.
- Bit placement: while bit counter cnt < FIXWID, the sampled bit is written to word[FIXWID-1-cnt]. Bits at cnt >= FIXWID are discarded. A slot shorter than FIXWID leaves the unfilled low bits at 0 (left-justified).
- Counter: cnt saturates at 63.
- Framing error: if cnt reaches MAX_SLOT_BITS without a slot end, frame_err is set.
- Slot end: a bclk rising edge on which sampled lrclk differs from prev_lrclk. The bit sampled on that edge is the LSB position of the previous slot (one-bit delay) and is placed by the rule above.
  - The completed word belongs to channel prev_lrclk.
  - cnt restarts at 0 and word is cleared on the following cycle.
- Sample ready, one cycle after the slot end:
  - chan_sel=00: left slot completes.
  - chan_sel=01: right slot completes.
  - chan_sel=10: right slot completes. The output is the sign-extended (FIXWID+1)-bit sum of the held left sample and the right sample, arithmetic shifted right by 1. It never overflows.
  - chan_sel=11: never.
  - A left slot always updates the held left sample.
- Handshake: ack_d registers ack each enabled cycle; ack_x = ack ^ ack_d.
  - ack_x clears busy.
  - On sample ready with busy=0, or with ack_x=1 in the same cycle: rx_data <= sample, req <= ~req, busy <= 1. Ack is processed first.
  - On sample ready with busy=1 and ack_x=0: the sample is dropped, overrun <= 1, rx_data and req are unchanged.
- Latency: req toggles 2 clk after the clk edge on which the final bclk rising edge is detected (edge detect, then ready/issue), excluding synchroniser delay.
- err_clr: clears overrun and frame_err. If a set condition occurs in the same cycle, set wins.
- chan_sel: may change at any time. The new value takes effect at the next slot end; an outstanding request is not affected.
- rst mid-transfer: req returns to 0 and busy to 0. The downstream side must also be reset, since its toggle detector would otherwise see a spurious edge.
- enable low: synchronisers also hold, so BCLK edges that occur while disabled are lost. This is acceptable.

Decomposition:
- Shared package/include (alongside the fixnum defines): FIXWID; chan_sel encodings CH_LEFT, CH_RIGHT, CH_MIX, CH_MUTE.
- One natural sub-module: i2s_sync_edge, which holds the SYNC_STAGES synchroniser, the bclk rise detect, and the lrclk change detect.
- The deserialiser and handshake stay in the top module.

Test Plan:
1. Reset, then chan_sel=00. Send an I2S frame with 32-bit slots, L=0x1234_xxxx, R=0xABCD_xxxx, and ack looped back 3 clk after each req toggle. Expect one req toggle per frame with rx_data=0x1234; overrun=0.
2. chan_sel=10, L=0x4000, R=0x2000 (16-bit slots) -> rx_data=0x3000. Then L=0x8000, R=0x8000 -> rx_data=0x8000. No overflow.
3. Hold ack constant across two frames with chan_sel=00, L=0x1111 then 0x2222. Expect rx_data stays 0x1111, overrun=1 and busy=1. A single err_clr pulse returns overrun to 0.
4. Send 12-bit slots with L=0xABC -> rx_data=0xABC0. Send a 40-bit slot -> frame_err=1 after bit 32; the slot's sample is still issued from its first 16 bits.
5. chan_sel=11 for 4 frames -> req never toggles. Then switch to 01 mid-frame -> the first toggle carries the next complete right slot.
6. Assert rst while busy=1 -> on the next clk req=0, busy=0, rx_data=0. Deassert enable for 10 clk mid-slot -> no outputs change.

Source files
------------

// File: rtl/i2s_ns_feeder_pkg.sv
// Shared definitions for the I2S front end of the noise suppressor.
// Purpose: sample width, channel-select encodings, counter sizing, channel mix helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package i2s_ns_feeder_pkg;

  // Sample width; must match the suppressor datapath width.
  localparam int FIXWID = 16;

  // Bit counter width; the counter saturates at its all-ones value.
  localparam int                CNT_W   = 6;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    CH_LEFT  = 2'b00,
    CH_RIGHT = 2'b01,
    CH_MIX   = 2'b10,
    CH_MUTE  = 2'b11
  } chan_sel_t;

  // (L+R)>>>1 computed at FIXWID+1 bits, so it can never overflow.
  function automatic logic [FIXWID-1:0] mix_avg(input logic [FIXWID-1:0] a,
                                                input logic [FIXWID-1:0] b);
    logic [FIXWID:0] sum;
    sum = {a[FIXWID-1], a} + {b[FIXWID-1], b};
    return sum[FIXWID:1];
  endfunction

endpackage

// File: rtl/i2s_ns_feeder_if.sv
// Toggle req/ack sample hand-off between the I2S feeder and the suppressor.
// Purpose: bundles rx_data/req/busy (feeder side) and ack (suppressor side).
// Latency: n/a. Backpressure: one outstanding request; ack toggle completes it.
interface i2s_ns_feeder_if;
  import i2s_ns_feeder_pkg::*;

  logic [FIXWID-1:0] rx_data;  // held stable from the req toggle until ack
  logic              req;      // toggles once per issued sample
  logic              ack;      // toggles once per consumed sample
  logic              busy;     // request outstanding

  modport master (output rx_data, output req, output busy, input ack);
  modport slave  (input rx_data, input req, input busy, output ack);
endinterface

// File: rtl/i2s_sync_edge.sv
// Synchronises the asynchronous I2S pins and detects bit and slot boundaries.
// Latency: SYNC_STAGES clk from pin to bit_vld. Backpressure: none; edges seen
// while enable is low are lost.
// Ports: clk/rst/enable; bclk/lrclk/sdata async pins; bit_vld = bclk rise,
// bit_dat = sampled data, lr_prev = word select of the slot in progress,
// slot_end = bclk rise on which the sampled word select changed.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  output logic bit_vld,
  output logic bit_dat,
  output logic lr_prev,
  output logic slot_end
);

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   bclk_prev;
  logic                   lr_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
      lr_prev    <= 1'b0;
    end else if (enable) begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      bclk_prev  <= bclk_sync[SYNC_STAGES-1];
      // Word select is only meaningful at bclk rising edges.
      if (bit_vld) lr_prev <= lr_now;
    end
  end

  assign lr_now   = lrclk_sync[SYNC_STAGES-1];
  assign bit_dat  = sdata_sync[SYNC_STAGES-1];
  assign bit_vld  = bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
  assign slot_end = bit_vld & (lr_now != lr_prev);

endmodule

// File: rtl/i2s_ns_feeder.sv
// I2S receiver feeding the noise suppressor: deserialise, select/mix, hand off.
// Latency: req toggles 2 clk after the final bclk rise is detected (plus sync).
// Backpressure: one outstanding request; a sample arriving while busy is dropped
// and flagged in sticky overrun.
// Ports: clk, rst (sync, active high), enable (global hold), i2s_bclk/lrclk/sdata
// (async I2S pins), chan_sel (left/right/mix/mute), err_clr (clears sticky flags),
// overrun, frame_err (sticky flags), dn (rx_data/req/busy out, ack in).
module i2s_ns_feeder
  import i2s_ns_feeder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int MAX_SLOT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrclk,
  input  logic                   i2s_sdata,
  input  logic [1:0]             chan_sel,
  input  logic                   err_clr,
  output logic                   overrun,
  output logic                   frame_err,
  i2s_ns_feeder_if.master        dn
);

  logic              bit_vld;
  logic              bit_dat;
  logic              lr_prev;
  logic              slot_end;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [FIXWID-1:0] word;
  logic [FIXWID-1:0] word_nxt;
  logic [FIXWID-1:0] held_left;
  logic              done;       // cycle after a slot end: word is complete
  logic              done_chan;  // channel of the completed word (1 = right)
  chan_sel_t         sel_q;      // chan_sel captured at the slot end
  logic              ack_d;

  logic              ack_x;
  logic              ready;
  logic [FIXWID-1:0] sample;
  logic              issue;
  logic              drop;
  logic              ferr_set;

  i2s_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .bclk     (i2s_bclk),
    .lrclk    (i2s_lrclk),
    .sdata    (i2s_sdata),
    .bit_vld  (bit_vld),
    .bit_dat  (bit_dat),
    .lr_prev  (lr_prev),
    .slot_end (slot_end)
  );

  // Deserialiser: bit number cnt lands MSB-first; bits past FIXWID are ignored,
  // short slots leave the low bits at zero.
  always_comb begin
    word_nxt = word;
    for (int i = 0; i < FIXWID; i++) begin
      if (int'(cnt) == FIXWID - 1 - i) word_nxt[i] = bit_dat;
    end
    cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    // The edge that ends a slot carries its last bit, so reaching the limit
    // on that edge is still a legal slot length.
    ferr_set = bit_vld & ~slot_end & (int'(cnt_inc) >= MAX_SLOT_BITS);
  end

  // Sample selection and request issue.
  always_comb begin
    ready  = 1'b0;
    sample = word;
    if (done) begin
      case (sel_q)
        CH_LEFT:  ready = ~done_chan;
        CH_RIGHT: ready = done_chan;
        CH_MIX: begin
          ready  = done_chan;
          sample = mix_avg(held_left, word);
        end
        default:  ready = 1'b0;
      endcase
    end
    ack_x = dn.ack ^ ack_d;
    // A same-cycle ack frees the slot before the new sample is considered.
    issue = ready & (~dn.busy | ack_x);
    drop  = ready & dn.busy & ~ack_x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      word       <= '0;
      held_left  <= '0;
      done       <= 1'b0;
      done_chan  <= 1'b0;
      sel_q      <= CH_LEFT;
      ack_d      <= 1'b0;
      dn.rx_data <= '0;
      dn.req     <= 1'b0;
      dn.busy    <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else if (enable) begin
      ack_d <= dn.ack;
      done  <= 1'b0;

      if (bit_vld) begin
        word <= word_nxt;
        cnt  <= cnt_inc;
        if (slot_end) begin
          done      <= 1'b1;
          done_chan <= lr_prev;
          sel_q     <= chan_sel_t'(chan_sel);
        end
      end

      // Consume the completed word and restart for the slot already underway.
      if (done) begin
        word <= '0;
        cnt  <= '0;
        if (!done_chan) held_left <= word;
      end

      if (issue) begin
        dn.rx_data <= sample;
        dn.req     <= ~dn.req;
        dn.busy    <= 1'b1;
      end else if (ack_x) begin
        dn.busy    <= 1'b0;
      end

      // Set takes priority over clear.
      overrun   <= drop     | (overrun   & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_i2s_ns_feeder.sv
// Randomised scoreboard bench for i2s_ns_feeder: slot-level I2S driver, a
// behavioural model that predicts issued samples, and a req-toggle monitor.
module tb_i2s_ns_feeder;
  import i2s_ns_feeder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       bclk = 1'b0;
  logic       lrclk = 1'b0;
  logic       sdata = 1'b0;
  logic [1:0] chan_sel = CH_MUTE;
  logic       err_clr = 1'b0;
  logic       overrun;
  logic       frame_err;

  i2s_ns_feeder_if dn();

  i2s_ns_feeder #(
    .SYNC_STAGES   (2),
    .MAX_SLOT_BITS (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .i2s_bclk  (bclk),
    .i2s_lrclk (lrclk),
    .i2s_sdata (sdata),
    .chan_sel  (chan_sel),
    .err_clr   (err_clr),
    .overrun   (overrun),
    .frame_err (frame_err),
    .dn        (dn)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_toggles = 0;
  logic [FIXWID-1:0] exp_q[$];

  // Reference model state (slot-level view of the I2S stream)
  logic        pend_ch;
  int          pend_n;
  logic [63:0] pend_val;
  logic        carry;
  logic [15:0] m_held;
  logic        m_busy, m_req, m_ovr, m_ferr;
  bit          ack_on = 1'b0;
  logic        req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend_ch = 1'b0; pend_n = 0; pend_val = '0; carry = 1'b0;
    m_held = '0; m_busy = 1'b0; m_req = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // The pending slot finishes: work out what the feeder should hand downstream.
  task automatic model_slot_end();
    logic [15:0] w;
    logic [15:0] s;
    int          sum;
    logic        rdy;
    for (int i = 0; i < 16; i++) w[15-i] = (i < pend_n) ? pend_val[63-i] : 1'b0;
    if (pend_n > 32) m_ferr = 1'b1;
    rdy = 1'b0;
    s = w;
    if (!pend_ch) begin
      rdy = (chan_sel == CH_LEFT);
    end else begin
      rdy = (chan_sel == CH_RIGHT) || (chan_sel == CH_MIX);
      if (chan_sel == CH_MIX) begin
        sum = (int'($signed(m_held)) + int'($signed(w))) >>> 1;
        s = sum[15:0];
      end
    end
    if (!pend_ch) m_held = w;
    if (rdy) begin
      if (m_busy) m_ovr = 1'b1;
      else begin
        exp_q.push_back(s);
        m_req = ~m_req;
        if (!ack_on) m_busy = 1'b1;
      end
    end
  endtask

  task automatic bclk_period(input logic lr, input logic sd);
    @(negedge clk);
    bclk = 1'b0; lrclk = lr; sdata = sd;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // One slot on the wire; its first period carries the previous slot's last bit.
  task automatic send_slot(input logic ch, input int n, input logic [63:0] val);
    model_slot_end();
    for (int i = 0; i < n; i++) begin
      if (i == 0) bclk_period(ch, carry);
      else        bclk_period(ch, val[64-i]);
    end
    carry = val[64-n];
    pend_ch = ch; pend_n = n; pend_val = val;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every req toggle must deliver the next predicted sample.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) req_prev = dn.req;
      else if (dn.req !== req_prev) begin
        req_prev = dn.req;
        n_toggles++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_req: got toggle with rx_data %h expected no request", dn.rx_data);
        end else begin
          check("sample", 32'(dn.rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Downstream responder: returns ack 3 clk after each req toggle.
  initial begin
    dn.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_on && !rst && (dn.req !== dn.ack)) begin
        repeat (3) @(negedge clk);
        if (ack_on && !rst) dn.ack = ~dn.ack;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    logic [63:0] v;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_rx_data", 32'(dn.rx_data), 32'h0);
    check("rst_req", 32'(dn.req), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(dn.busy), 32'h0);
    rst = 1'b0;
    ack_on = 1'b1;
    chan_sel = CH_MUTE;
    send_slot(1'b1, 4, 64'h0);

    // 1: left channel, 32-bit slots
    chan_sel = CH_LEFT;
    t0 = n_toggles;
    send_slot(1'b0, 32, {16'h1234, 48'(rnd64())});
    send_slot(1'b1, 32, {16'hABCD, 48'(rnd64())});
    check("t1_rx_data", 32'(dn.rx_data), 32'h1234);
    check("t1_overrun", 32'(overrun), 32'h0);
    check("t1_toggles", 32'(n_toggles - t0), 32'd1);

    // 2: mix channel, including full negative scale
    chan_sel = CH_MIX;
    send_slot(1'b0, 16, {16'h4000, 48'h0});
    send_slot(1'b1, 16, {16'h2000, 48'h0});
    send_slot(1'b0, 16, {16'h8000, 48'h0});
    check("t2_mix_a", 32'(dn.rx_data), 32'h3000);
    send_slot(1'b1, 16, {16'h8000, 48'h0});
    send_slot(1'b0, 16, rnd64());
    check("t2_mix_neg", 32'(dn.rx_data), 32'h8000);
    send_slot(1'b1, 16, rnd64());

    // Random frames, random selection and slot lengths
    for (int k = 0; k < 8; k++) begin
      chan_sel = 2'($urandom_range(0, 2));
      send_slot(1'b0, $urandom_range(8, 32), rnd64());
      send_slot(1'b1, $urandom_range(8, 32), rnd64());
    end

    // 4: short slots left-justify; overlong slot flags frame_err
    chan_sel = CH_LEFT;
    send_slot(1'b0, 12, {12'hABC, 52'h0});
    send_slot(1'b1, 12, rnd64());
    check("t4_short", 32'(dn.rx_data), 32'hABC0);
    check("t4_no_ferr", 32'(frame_err), 32'h0);
    v = rnd64();
    send_slot(1'b0, 40, v);
    send_slot(1'b1, 16, rnd64());
    check("t4_ferr", 32'(frame_err), 32'h1);
    check("t4_long_sample", 32'(dn.rx_data), 32'(v[63:48]));

    // 5: mute, then switch to right mid-frame
    chan_sel = CH_MUTE;
    t0 = n_toggles;
    for (int k = 0; k < 4; k++) begin
      send_slot(1'b0, $urandom_range(16, 32), rnd64());
      send_slot(1'b1, $urandom_range(16, 32), rnd64());
    end
    check("t5_mute", 32'(n_toggles - t0), 32'd0);
    send_slot(1'b0, 16, rnd64());
    chan_sel = CH_RIGHT;
    send_slot(1'b1, 24, {16'hCAFE, 48'(rnd64())});
    send_slot(1'b0, 16, rnd64());
    check("t5_switch_cnt", 32'(n_toggles - t0), 32'd1);
    check("t5_switch_data", 32'(dn.rx_data), 32'hCAFE);
    send_slot(1'b1, 16, rnd64());

    // 3: no ack -> overrun; enable low freezes everything
    chan_sel = CH_LEFT;
    ack_on = 1'b0;
    send_slot(1'b0, 16, {16'h1111, 48'h0});
    send_slot(1'b1, 16, rnd64());
    send_slot(1'b0, 16, {16'h2222, 48'h0});
    send_slot(1'b1, 16, rnd64());
    check("t3_rx_hold", 32'(dn.rx_data), 32'h1111);
    check("t3_overrun", 32'(overrun), 32'(m_ovr));
    check("t3_busy", 32'(dn.busy), 32'h1);
    enable = 1'b0;
    dn.ack = ~dn.ack;
    err_clr = 1'b1;
    repeat (10) @(negedge clk);
    check("en_overrun", 32'(overrun), 32'h1);
    check("en_busy", 32'(dn.busy), 32'h1);
    check("en_req", 32'(dn.req), 32'(m_req));
    check("en_rx", 32'(dn.rx_data), 32'h1111);
    err_clr = 1'b0;
    dn.ack = ~dn.ack;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    check("t3_clr_overrun", 32'(overrun), 32'h0);
    check("t3_clr_ferr", 32'(frame_err), 32'h0);
    ack_on = 1'b1;
    repeat (10) @(negedge clk);
    m_busy = 1'b0;
    check("t3_ack_busy", 32'(dn.busy), 32'h0);

    // 6: reset while busy
    ack_on = 1'b0;
    send_slot(1'b0, 16, rnd64());
    send_slot(1'b1, 16, rnd64());
    check("t6_busy", 32'(dn.busy), 32'h1);
    @(negedge clk);
    bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_req", 32'(dn.req), 32'h0);
    check("t6_busy0", 32'(dn.busy), 32'h0);
    check("t6_rx", 32'(dn.rx_data), 32'h0);
    dn.ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ack_on = 1'b1;
    chan_sel = CH_MUTE;
    send_slot(1'b1, 4, 64'h0);
    chan_sel = CH_RIGHT;
    for (int k = 0; k < 3; k++) begin
      send_slot(1'b0, $urandom_range(16, 32), rnd64());
      send_slot(1'b1, $urandom_range(16, 32), rnd64());
    end
    send_slot(1'b0, 16, rnd64());

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("end_overrun", 32'(overrun), 32'(m_ovr));
    check("end_frame_err", 32'(frame_err), 32'(m_ferr));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
